// File: rtl/vga_buffer_arbiter_pkg.sv
// Shared constants and types for the VGA frame-RAM arbiter.
// Image geometry defaults match the 320x240x12 frame buffer.
package vga_buffer_arbiter_pkg;

    localparam int IMAGE_WIDTH  = 320;
    localparam int IMAGE_HEIGHT = 240;
    localparam int VGA_ADDR_W   = 17;
    localparam int WR_WAIT_DEF  = 8;

    localparam int PIX_W = 12;
    localparam int ROW_W = 8;
    localparam int COL_W = 9;

    // One slot of the display read pipe: a live read and whether it hit the image.
    typedef struct packed {
        logic valid;
        logic oob;
    } rd_stage_t;

    // Down-counter width able to hold max_wait; never narrower than one bit.
    function automatic int wait_width(input int max_wait);
        return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
    endfunction

endpackage

// File: rtl/vga_buffer_arbiter_pixel_addr_calc.sv
// Row/column to linear frame-RAM word address, plus an in-image flag.
// Purely combinational; one copy serves the display side, one the writer.
module vga_buffer_arbiter_pixel_addr_calc
    import vga_buffer_arbiter_pkg::*;
#(
    parameter int IMG_W  = IMAGE_WIDTH,
    parameter int IMG_H  = IMAGE_HEIGHT,
    parameter int ADDR_W = VGA_ADDR_W
) (
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    // Constant multiply reduces to (row<<8)+(row<<6) for a 320-pixel line.
    always_comb begin
        addr     = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
        in_range = (32'(row) < 32'(IMG_H)) && (32'(col) < 32'(IMG_W));
    end

endmodule

// File: rtl/vga_buffer_arbiter.sv
// Single-port frame-RAM arbiter: display reads have priority, the mask writer
// takes free cycles, and a bounded-wait guard forces a write after WR_MAX_WAIT stalls.
module vga_buffer_arbiter
    import vga_buffer_arbiter_pkg::*;
#(
    parameter int IMG_W       = IMAGE_WIDTH,
    parameter int IMG_H       = IMAGE_HEIGHT,
    parameter int ADDR_W      = VGA_ADDR_W,
    parameter int WR_MAX_WAIT = WR_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ROW_W-1:0]  disp_row,
    input  logic [COL_W-1:0]  disp_col,
    output logic [PIX_W-1:0]  disp_pixel,
    output logic              disp_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [PIX_W-1:0]  wr_pixel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata,
    output logic              frame_done,
    output logic              disp_miss,
    output logic              wr_oob
);

    localparam int                WAIT_W    = wait_width(WR_MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WR_MAX_WAIT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam bit                GUARD_EN  = (WR_MAX_WAIT != 0);

    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              disp_in_range;
    logic              wr_in_range;

    logic [WAIT_W-1:0] wait_left;
    logic              guard_hit;
    logic              wr_xfer;
    logic              rd_grant;
    logic              rd_drop;

    rd_stage_t         rd_s1;
    rd_stage_t         rd_s2;

    vga_buffer_arbiter_pixel_addr_calc #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_disp_addr (
        .row      (disp_row),
        .col      (disp_col),
        .addr     (disp_addr),
        .in_range (disp_in_range)
    );

    vga_buffer_arbiter_pixel_addr_calc #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_wr_addr (
        .row      (wr_row),
        .col      (wr_col),
        .addr     (wr_addr),
        .in_range (wr_in_range)
    );

    // Grant for this cycle; the RAM port registers pick up the winner next edge.
    always_comb begin
        guard_hit = GUARD_EN && (wait_left == '0);
        wr_ready  = ~rst & (~disp_req | guard_hit);
        wr_xfer   = wr_valid & wr_ready;
        rd_grant  = disp_req & ~rst & ~wr_xfer;
        rd_drop   = disp_req & wr_xfer;
    end

    // Down-counter of remaining stall cycles; reloaded whenever the writer is not stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_left <= WAIT_LOAD;
        end else if (!wr_valid || wr_xfer) begin
            wait_left <= WAIT_LOAD;
        end else if (wait_left != '0) begin
            wait_left <= wait_left - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= '0;
            frame_done <= 1'b0;
            disp_miss  <= 1'b0;
            wr_oob     <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            frame_done <= 1'b0;
            if (wr_xfer) begin
                if (wr_in_range) begin
                    ram_we     <= 1'b1;
                    ram_addr   <= wr_addr;
                    ram_wdata  <= wr_pixel;
                    frame_done <= (wr_addr == LAST_ADDR);
                end else begin
                    wr_oob <= 1'b1;
                end
            end else if (rd_grant && disp_in_range) begin
                ram_addr <= disp_addr;
            end
            if (rd_drop) begin
                disp_miss <= 1'b1;
            end
        end
    end

    // Read pipe: s1 aligns with ram_addr, s2 with ram_rdata, then the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_s1      <= '0;
            rd_s2      <= '0;
            disp_valid <= 1'b0;
            disp_pixel <= '0;
        end else begin
            rd_s1      <= '{valid: rd_grant, oob: ~disp_in_range};
            rd_s2      <= rd_s1;
            disp_valid <= rd_s2.valid;
            if (rd_s2.valid) begin
                disp_pixel <= rd_s2.oob ? '0 : ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_buffer_arbiter.sv
// Directed bench for vga_buffer_arbiter: guarded instance (WR_MAX_WAIT=8) fully scoreboarded,
// unguarded instance (WR_MAX_WAIT=0) counted during the starvation scenario.
module tb_vga_buffer_arbiter;
    import vga_buffer_arbiter_pkg::*;

    localparam int MAXW_A = 8;
    localparam int NWORDS = 76800;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic [7:0]  disp_row = '0;
    logic [8:0]  disp_col = '0;
    logic        wr_valid = 1'b0;
    logic        wr_valid_b = 1'b0;
    logic [7:0]  wr_row = '0;
    logic [8:0]  wr_col = '0;
    logic [11:0] wr_pixel = '0;

    logic [11:0] disp_pixel_a, disp_pixel_b;
    logic        disp_valid_a, disp_valid_b;
    logic        wr_ready_a, wr_ready_b;
    logic [16:0] ram_addr_a, ram_addr_b;
    logic        ram_we_a, ram_we_b;
    logic [11:0] ram_wdata_a, ram_wdata_b;
    logic [11:0] ram_rdata_a, ram_rdata_b;
    logic        frame_done_a, frame_done_b;
    logic        disp_miss_a, disp_miss_b;
    logic        wr_oob_a, wr_oob_b;

    vga_buffer_arbiter #(.WR_MAX_WAIT(MAXW_A)) dut_a (
        .clk(clk), .rst(rst), .disp_req(disp_req), .disp_row(disp_row), .disp_col(disp_col),
        .disp_pixel(disp_pixel_a), .disp_valid(disp_valid_a), .wr_valid(wr_valid),
        .wr_ready(wr_ready_a), .wr_row(wr_row), .wr_col(wr_col), .wr_pixel(wr_pixel),
        .ram_addr(ram_addr_a), .ram_we(ram_we_a), .ram_wdata(ram_wdata_a),
        .ram_rdata(ram_rdata_a), .frame_done(frame_done_a), .disp_miss(disp_miss_a),
        .wr_oob(wr_oob_a)
    );

    vga_buffer_arbiter #(.WR_MAX_WAIT(0)) dut_b (
        .clk(clk), .rst(rst), .disp_req(disp_req), .disp_row(disp_row), .disp_col(disp_col),
        .disp_pixel(disp_pixel_b), .disp_valid(disp_valid_b), .wr_valid(wr_valid_b),
        .wr_ready(wr_ready_b), .wr_row(wr_row), .wr_col(wr_col), .wr_pixel(wr_pixel),
        .ram_addr(ram_addr_b), .ram_we(ram_we_b), .ram_wdata(ram_wdata_b),
        .ram_rdata(ram_rdata_b), .frame_done(frame_done_b), .disp_miss(disp_miss_b),
        .wr_oob(wr_oob_b)
    );

    // Unwritten RAM words read back as a fixed address-derived pattern.
    function automatic logic [11:0] pat(input logic [16:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    logic [11:0] mem_a [0:NWORDS-1];
    bit          flg_a [0:NWORDS-1];
    logic [11:0] mem_b [0:NWORDS-1];
    bit          flg_b [0:NWORDS-1];

    always @(posedge clk) begin
        if (ram_we_a && ram_addr_a < 17'(NWORDS)) begin
            mem_a[ram_addr_a] <= ram_wdata_a;
            flg_a[ram_addr_a] <= 1'b1;
        end
        if (ram_addr_a < 17'(NWORDS))
            ram_rdata_a <= flg_a[ram_addr_a] ? mem_a[ram_addr_a] : pat(ram_addr_a);
        else
            ram_rdata_a <= 12'hEEE;
    end

    always @(posedge clk) begin
        if (ram_we_b && ram_addr_b < 17'(NWORDS)) begin
            mem_b[ram_addr_b] <= ram_wdata_b;
            flg_b[ram_addr_b] <= 1'b1;
        end
        if (ram_addr_b < 17'(NWORDS))
            ram_rdata_b <= flg_b[ram_addr_b] ? mem_b[ram_addr_b] : pat(ram_addr_b);
        else
            ram_rdata_b <= 12'hEEE;
    end

    typedef struct {
        int          cyc;
        logic [11:0] pix;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wcnt = 0;
    bit          miss_m = 1'b0;
    bit          oob_m = 1'b0;
    int          dv_a = 0, we_a = 0, dv_b = 0, we_b = 0;
    logic [11:0] sh     [0:NWORDS-1];
    bit          sh_flg [0:NWORDS-1];

    function automatic logic [16:0] lin(input logic [7:0] r, input logic [8:0] c);
        return 17'(r) * 17'd320 + 17'(c);
    endfunction

    function automatic bit inr(input logic [7:0] r, input logic [8:0] c);
        return (r < 8'd240) && (c < 9'd320);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check the combinational grant, clock, check registered outputs.
    task automatic step(input bit r, input bit dq, input logic [7:0] drow, input logic [8:0] dcol,
                        input bit wv, input bit wvb, input logic [7:0] wrw, input logic [8:0] wcl,
                        input logic [11:0] wpx, output bit xfer);
        bit          exp_rdy, rd_ok, exp_we, exp_fd;
        logic [16:0] wa, da;
        logic [11:0] epix;
        rst = r; disp_req = dq; disp_row = drow; disp_col = dcol;
        wr_valid = wv; wr_valid_b = wvb; wr_row = wrw; wr_col = wcl; wr_pixel = wpx;
        exp_rdy = !r && (!dq || (MAXW_A != 0 && wcnt == MAXW_A));
        #1;
        chk("wr_ready", wr_ready_a, exp_rdy);
        xfer   = wv && exp_rdy;
        rd_ok  = dq && !r && !xfer;
        wa     = lin(wrw, wcl);
        da     = lin(drow, dcol);
        exp_we = xfer && inr(wrw, wcl);
        exp_fd = exp_we && (wa == 17'd76799);
        if (r) begin
            sbq.delete();
            wcnt = 0; miss_m = 1'b0; oob_m = 1'b0;
        end else begin
            if (dq && xfer) miss_m = 1'b1;
            if (xfer && !inr(wrw, wcl)) oob_m = 1'b1;
            if (rd_ok) begin
                epix = 12'h000;
                if (inr(drow, dcol)) epix = sh_flg[da] ? sh[da] : pat(da);
                sbq.push_back('{cyc: cyc + 3, pix: epix});
            end
            wcnt = (!wv || xfer) ? 0 : wcnt + 1;
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("ram_we", ram_we_a, exp_we);
        if (exp_we) begin
            chk("ram_addr_wr", ram_addr_a, wa);
            chk("ram_wdata", ram_wdata_a, wpx);
            sh[wa] = wpx;
            sh_flg[wa] = 1'b1;
        end
        chk("frame_done", frame_done_a, exp_fd);
        chk("disp_miss", disp_miss_a, miss_m);
        chk("wr_oob", wr_oob_a, oob_m);
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            chk("disp_valid_hi", disp_valid_a, 1);
            chk("disp_pixel", disp_pixel_a, sbq[0].pix);
            void'(sbq.pop_front());
        end else begin
            chk("disp_valid_lo", disp_valid_a, 0);
        end
        if (disp_valid_a) dv_a++;
        if (ram_we_a) we_a++;
        if (disp_valid_b) dv_b++;
        if (ram_we_b) we_b++;
    endtask

    task automatic idle(input int n);
        bit x;
        for (int i = 0; i < n; i++) step(0, 0, 8'd0, 9'd0, 0, 0, 8'd0, 9'd0, 12'h0, x);
    endtask

    initial begin
        bit x;
        bit wpend;
        int c, rd_cnt, dv0, we0, dvb0, web0;

        // 1: reset held, then released
        for (int i = 0; i < 3; i++) step(1, 0, 8'd0, 9'd0, 0, 0, 8'd0, 9'd0, 12'h0, x);
        chk("rst_ram_addr", ram_addr_a, 0);
        chk("rst_ram_wdata", ram_wdata_a, 0);
        chk("rst_disp_pixel", disp_pixel_a, 0);
        idle(1);

        // 2: read (1,2) after RAM holds ABC there
        step(0, 0, 8'd0, 9'd0, 1, 1, 8'd1, 9'd2, 12'hABC, x);
        idle(1);
        step(0, 1, 8'd1, 9'd2, 0, 0, 8'd0, 9'd0, 12'h0, x);
        chk("t2_ram_addr_rd", ram_addr_a, 322);
        chk("t2_ram_we_rd", ram_we_a, 0);
        idle(3);

        // 3: last pixel of the frame
        step(0, 0, 8'd0, 9'd0, 1, 1, 8'd239, 9'd319, 12'hF0F, x);
        chk("t3_frame_done", frame_done_a, 1);
        idle(2);

        // 4: continuous display reads against a waiting writer
        dv0 = dv_a; dvb0 = dv_b; web0 = we_b; we0 = we_a;
        wpend = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 8'd10, 9'(i), wpend, 1, 8'd5, 9'd5, 12'h123, x);
            if (x) wpend = 1'b0;
        end
        idle(4);
        chk("t4_pulses_a", dv_a - dv0, 19);
        chk("t4_writes_a", we_a - we0, 1);
        chk("t4_miss_a", disp_miss_a, 1);
        chk("t4_pulses_b", dv_b - dvb0, 20);
        chk("t4_writes_b", we_b - web0, 0);
        chk("t4_miss_b", disp_miss_b, 0);

        // 5: out-of-range write and read
        step(0, 0, 8'd0, 9'd0, 1, 1, 8'd240, 9'd0, 12'h7AB, x);
        chk("t5_oob", wr_oob_a, 1);
        step(0, 1, 8'd0, 9'd320, 0, 0, 8'd0, 9'd0, 12'h0, x);
        idle(3);
        chk("t5_oob_pixel", disp_pixel_a, 0);
        step(1, 0, 8'd0, 9'd0, 0, 0, 8'd0, 9'd0, 12'h0, x);
        step(1, 0, 8'd0, 9'd0, 0, 0, 8'd0, 9'd0, 12'h0, x);
        idle(1);

        // 6: alternating reads with a 320-pixel write stream
        c = 0; rd_cnt = 0; dv0 = dv_a; we0 = we_a;
        for (int s = 0; s < 700 && c < 320; s++) begin
            step(0, s[0], 8'd50, 9'(s % 320), 1, 1, 8'd100, 9'(c), 12'(c) ^ 12'hC3C, x);
            if (s[0] && !x) rd_cnt++;
            if (x) c++;
        end
        idle(4);
        chk("t6_writes", we_a - we0, 320);
        chk("t6_reads", dv_a - dv0, rd_cnt);
        step(0, 1, 8'd100, 9'd0, 0, 0, 8'd0, 9'd0, 12'h0, x);
        step(0, 1, 8'd100, 9'd160, 0, 0, 8'd0, 9'd0, 12'h0, x);
        step(0, 1, 8'd100, 9'd319, 0, 0, 8'd0, 9'd0, 12'h0, x);
        idle(4);

        // reset in the middle of a stream with reads in flight
        for (int s = 0; s < 7; s++)
            step(0, s[0], 8'd60, 9'(s), 1, 1, 8'd101, 9'(s), 12'h055, x);
        dv0 = dv_a;
        step(1, 1, 8'd60, 9'd9, 1, 1, 8'd101, 9'd9, 12'h055, x);
        idle(3);
        chk("t6_no_valid_after_rst", dv_a - dv0, 0);
        chk("t6_sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
